// File: rtl/axi_ic_pkg.sv
// Shared write-interconnect types: scheduler state encoding and index-width helper.
// Pure definitions; no logic, no latency, no flow control.
package axi_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_prio_pick.sv
// Masked fixed-priority picker (index 0 wins); falls back to the raw request vector when the mask hides all.
// Purely combinational, zero latency; no flow control of its own.
module wr_prio_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] eff;

    always_comb begin
        eff = req & ~mask;
        if (eff == '0) begin
            eff = req;
        end
        onehot = '0;
        idx    = '0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (eff[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/axi_wr_burst_scheduler.sv
// Fixed-priority AW/W/B grant holder with a bounded-starvation mask; 1-cycle request-to-grant, 0-cycle gap on B.
// All outputs registered; the block stalls in each phase until the matching valid&ready handshake.
module axi_wr_burst_scheduler
    import axi_ic_pkg::*;
#(
    parameter int M_NUM        = 3,
    parameter int STARVE_LIMIT = 4,
    parameter int IDX_W        = idx_width(M_NUM)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [M_NUM-1:0] s_awvalid,
    input  logic             m_awvalid,
    input  logic             m_awready,
    input  logic             m_wvalid,
    input  logic             m_wready,
    input  logic             m_wlast,
    input  logic             m_bvalid,
    input  logic             m_bready,
    output logic [M_NUM-1:0] grant,
    output logic [IDX_W-1:0] grant_index,
    output logic             grant_valid,
    output logic             aw_en,
    output logic             w_en,
    output logic             b_en
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    wr_state_e        state_q, state_d;
    logic [M_NUM-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_index_q, grant_index_d;
    logic             grant_valid_q, grant_valid_d;
    logic             aw_en_q, aw_en_d;
    logic             w_en_q, w_en_d;
    logic             b_en_q, b_en_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [M_NUM-1:0] mask_q, mask_d;

    logic [M_NUM-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             contended;
    logic             do_arb;

    wr_prio_pick #(
        .N     (M_NUM),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (s_awvalid),
        .mask   (mask_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign contended = |(s_awvalid & (s_awvalid - M_NUM'(1)));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_index_d = grant_index_q;
        win_cnt_d     = win_cnt_q;
        last_idx_d    = last_idx_q;
        mask_d        = mask_q;
        do_arb        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_arb = pick_any;
            end
            ST_ADDR: begin
                if (m_awvalid && m_awready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_wvalid && m_wready && m_wlast) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_bvalid && m_bready) begin
                    if (pick_any) begin
                        do_arb = 1'b1;
                    end else begin
                        state_d       = ST_IDLE;
                        grant_d       = '0;
                        grant_index_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_arb) begin
            state_d       = ST_ADDR;
            grant_d       = pick_onehot;
            grant_index_d = pick_idx;
            last_idx_d    = pick_idx;
            if (!contended) begin
                win_cnt_d = '0;
            end else if (pick_idx != last_idx_q) begin
                win_cnt_d = CNT_W'(1);
            end else if (win_cnt_q < LIMIT_C) begin
                win_cnt_d = win_cnt_q + CNT_W'(1);
            end
            // The mask lives for exactly one arbitration: every arbitration either re-arms or clears it.
            mask_d = ((STARVE_LIMIT != 0) && contended && (win_cnt_d == LIMIT_C)) ? pick_onehot : '0;
        end

        grant_valid_d = (state_d != ST_IDLE);
        aw_en_d       = (state_d == ST_ADDR);
        w_en_d        = (state_d == ST_DATA);
        b_en_d        = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_index_q <= '0;
            grant_valid_q <= 1'b0;
            aw_en_q       <= 1'b0;
            w_en_q        <= 1'b0;
            b_en_q        <= 1'b0;
            win_cnt_q     <= '0;
            last_idx_q    <= '0;
            mask_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
            grant_valid_q <= grant_valid_d;
            aw_en_q       <= aw_en_d;
            w_en_q        <= w_en_d;
            b_en_q        <= b_en_d;
            win_cnt_q     <= win_cnt_d;
            last_idx_q    <= last_idx_d;
            mask_q        <= mask_d;
        end
    end

    assign grant       = grant_q;
    assign grant_index = grant_index_q;
    assign grant_valid = grant_valid_q;
    assign aw_en       = aw_en_q;
    assign w_en        = w_en_q;
    assign b_en        = b_en_q;

    a_one_phase: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0({aw_en_q, w_en_q, b_en_q}));

    a_grant_shape: assert property (@(posedge clk) disable iff (!rstn)
        grant_valid_q ? $onehot(grant_q) : (grant_q == '0));

endmodule

// File: tb/tb_axi_wr_burst_scheduler.sv
// Randomized bench for axi_wr_burst_scheduler against a priority/streak reference model.
module tb_axi_wr_burst_scheduler;

    localparam int M   = 3;
    localparam int LIM = 4;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [M-1:0]  s_awvalid;
    logic          m_awvalid, m_awready;
    logic          m_wvalid, m_wready, m_wlast;
    logic          m_bvalid, m_bready;
    logic [M-1:0]  grant;
    logic [IW-1:0] grant_index;
    logic          grant_valid, aw_en, w_en, b_en;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: current streak owner/length and the master masked for the next pick.
    int m_last   = 0;
    int m_streak = 0;
    int m_masked = -1;
    int obs_idx[$];

    always #5 clk = ~clk;

    axi_wr_burst_scheduler #(
        .M_NUM        (M),
        .STARVE_LIMIT (LIM),
        .IDX_W        (IW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_awvalid   (s_awvalid),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_wlast     (m_wlast),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .grant       (grant),
        .grant_index (grant_index),
        .grant_valid (grant_valid),
        .aw_en       (aw_en),
        .w_en        (w_en),
        .b_en        (b_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [M-1:0] g, input logic v,
                           input logic a, input logic w, input logic b);
        logic [IW-1:0] ei;
        ei = '0;
        for (int i = 0; i < M; i++) begin
            if (g[i]) ei = IW'(i);
        end
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".index"}, 32'(grant_index), 32'(ei));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".aw_en"}, 32'(aw_en), 32'(a));
        chk({tag, ".w_en"}, 32'(w_en), 32'(w));
        chk({tag, ".b_en"}, 32'(b_en), 32'(b));
    endtask

    function automatic void model_reset();
        m_last   = 0;
        m_streak = 0;
        m_masked = -1;
    endfunction

    // Lowest requester outside the mask (or any requester if the mask hides all), then update the streak.
    function automatic int model_arb(input logic [M-1:0] req);
        logic [M-1:0] cand;
        int           w;
        bit           cont;
        cand = req;
        if (m_masked >= 0) cand[m_masked] = 1'b0;
        if (cand == '0) cand = req;
        w = 0;
        for (int i = M - 1; i >= 0; i--) begin
            if (cand[i]) w = i;
        end
        cont = ($countones(req) > 1);
        if (cont && w == m_last) m_streak = m_streak + 1;
        else m_streak = cont ? 1 : 0;
        m_last   = w;
        m_masked = (LIM != 0 && m_streak >= LIM) ? w : -1;
        return w;
    endfunction

    function automatic logic [M-1:0] next_req(input int mode, input logic [M-1:0] fixed);
        if (mode == 0) return fixed;
        return M'($urandom_range(1, (1 << M) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [M-1:0] g, input bit w_early);
        int st;
        st = $urandom_range(0, 2);
        for (int i = 0; i < st; i++) begin
            m_awvalid = 1'($urandom_range(0, 1));
            m_awready = ~m_awvalid;
            m_wvalid  = w_early;
            m_wready  = w_early;
            m_wlast   = w_early;
            tick();
            chk_out("aw_stall", g, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        m_awvalid = 1'b1;
        m_awready = 1'b1;
        m_wvalid  = 1'b0;
        m_wready  = 1'b0;
        m_wlast   = 1'b0;
        tick();
        m_awvalid = 1'b0;
        m_awready = 1'b0;
        chk_out("aw_hs", g, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_w(input logic [M-1:0] g, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            s_awvalid = M'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                m_wvalid = 1'b1;
                m_wready = 1'b0;
                m_wlast  = (b == nbeats - 1);
                tick();
                chk_out("w_stall", g, 1'b1, 1'b0, 1'b1, 1'b0);
            end
            m_wvalid = 1'b1;
            m_wready = 1'b1;
            m_wlast  = (b == nbeats - 1);
            tick();
            m_wvalid = 1'b0;
            m_wready = 1'b0;
            m_wlast  = 1'b0;
            if (b == nbeats - 1) chk_out("w_last", g, 1'b1, 1'b0, 1'b0, 1'b1);
            else chk_out("w_beat", g, 1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic do_b(input logic [M-1:0] g, input logic [M-1:0] nreq);
        int st;
        s_awvalid = nreq;
        st = $urandom_range(0, 2);
        for (int i = 0; i < st; i++) begin
            m_bvalid = 1'($urandom_range(0, 1));
            m_bready = ~m_bvalid;
            tick();
            chk_out("b_stall", g, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        m_bvalid = 1'b1;
        m_bready = 1'b1;
        tick();
        m_bvalid = 1'b0;
        m_bready = 1'b0;
    endtask

    // Runs n back-to-back bursts from IDLE; each next request set is presented during the B handshake.
    task automatic run_seq(input string tag, input int n, input int mode, input logic [M-1:0] fixed);
        logic [M-1:0] req, nreq, g;
        int           w;
        req = next_req(mode, fixed);
        s_awvalid = req;
        tick();
        for (int k = 0; k < n; k++) begin
            w = model_arb(req);
            g = '0;
            g[w] = 1'b1;
            obs_idx.push_back(int'(grant_index));
            chk_out({tag, ".arb"}, g, 1'b1, 1'b1, 1'b0, 1'b0);
            do_aw(g, 1'($urandom_range(0, 1)));
            do_w(g, $urandom_range(1, 4));
            nreq = (k == n - 1) ? '0 : next_req(mode, fixed);
            do_b(g, nreq);
            if (nreq == '0) chk_out({tag, ".idle"}, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            req = nreq;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int starve_exp[10];
        int w;
        starve_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rstn      = 1'b0;
        s_awvalid = '0;
        m_awvalid = 1'b0; m_awready = 1'b0;
        m_wvalid  = 1'b0; m_wready  = 1'b0; m_wlast = 1'b0;
        m_bvalid  = 1'b0; m_bready  = 1'b0;
        model_reset();
        #12;
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Two requesters, lower index 1 wins; four-beat burst; idle after B.
        s_awvalid = 3'b110;
        tick();
        w = model_arb(3'b110);
        chk("t1.model", 32'(w), 32'd1);
        chk_out("t1.arb", 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        do_aw(3'b010, 1'b1);
        do_w(3'b010, 4);
        do_b(3'b010, '0);
        chk_out("t1.idle", '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Constant contention: master 0 masked after every fourth consecutive win.
        obs_idx.delete();
        run_seq("starve", 10, 0, 3'b011);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("starve.seq%0d", k), 32'(obs_idx[k]), 32'(starve_exp[k]));
        end

        // A lone requester is never masked.
        obs_idx.delete();
        run_seq("solo", 6, 0, 3'b001);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("solo.seq%0d", k), 32'(obs_idx[k]), 32'd0);
        end

        // Asynchronous reset in the middle of the data phase.
        s_awvalid = 3'b001;
        tick();
        w = model_arb(3'b001);
        chk_out("rst.arb", 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
        do_aw(3'b001, 1'b0);
        rstn = 1'b0;
        #1;
        chk_out("rst.async", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_awvalid = 3'b100;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        w = model_arb(3'b100);
        chk_out("rst.rearb", 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
        do_aw(3'b100, 1'b1);
        do_w(3'b100, 2);
        do_b(3'b100, '0);
        chk_out("rst.idle", '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random request mixes with idle gaps in between.
        for (int r = 0; r < 4; r++) begin
            run_seq($sformatf("rnd%0d", r), 12, 1, '0);
            repeat ($urandom_range(0, 3)) tick();
            chk_out($sformatf("rnd%0d.gap", r), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_scheduler.md
Name: axi_wr_burst_scheduler

Overview:
- Control-only scheduler for the shared AXI write path in the interconnect: picks one of M_NUM write masters by fixed priority and holds that grant for the whole AW/W/B transaction.
- Bounded-starvation guard: a master that wins STARVE_LIMIT consecutive contended bursts is masked for one arbitration.
- Outputs drive the existing AW/W/B muxes/demuxes; no payload passes through this block.

Parameters:
- M_NUM, 3, number of write masters (2..8); index 0 = highest priority.
- STARVE_LIMIT, 4, consecutive contended wins before the winner is masked once; 0 disables the guard.
- IDX_W, $clog2(M_NUM), width of grant_index.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- s_awvalid  in  M_NUM  per-master AW request.
- m_awvalid  in  1  AWVALID after the mux, shared side.
- m_awready  in  1  AWREADY from the shared slave.
- m_wvalid  in  1  WVALID after the mux.
- m_wready  in  1  WREADY from the slave.
- m_wlast  in  1  WLAST after the mux.
- m_bvalid  in  1  BVALID from the slave.
- m_bready  in  1  BREADY after the demux.
- grant  out  M_NUM  one-hot owner; all zero when idle.
- grant_index  out  IDX_W  binary owner index.
- grant_valid  out  1  grant/grant_index are meaningful.
- aw_en  out  1  route AW channel of the owner.
- w_en  out  1  route W channel of the owner.
- b_en  out  1  route B channel to the owner.

Behaviour:
- Reset (async, rstn=0): state IDLE; grant=0, grant_index=0, grant_valid=0, aw_en=w_en=b_en=0; win_cnt=0, last_idx=0, mask=0. Mid-burst reset abandons the transaction immediately.
- All outputs are registered; at most one of aw_en/w_en/b_en is high.
- IDLE: if |s_awvalid, register the lowest-index set bit of (s_awvalid & ~mask), or of s_awvalid if the masked vector is zero; go to ADDR. Arbitration latency is 1 cycle from request to grant_valid.
- ADDR: grant_valid=1, aw_en=1. On m_awvalid&m_awready go to DATA. The owner dropping s_awvalid before the handshake is a protocol violation: hold ADDR, no timeout.
- DATA: w_en=1. On m_wvalid&m_wready&m_wlast go to RESP. Beats without wlast do not change state. W data arriving before AW is not supported; W is routed only in DATA.
- RESP: b_en=1. On m_bvalid&m_bready:
  - if any s_awvalid is high in that cycle, re-arbitrate and go straight to ADDR, giving a 0-cycle gap;
  - otherwise go to IDLE and clear grant/grant_valid.
- Starvation guard, evaluated at each arbitration:
  - A win is contended when another s_awvalid bit was also set.
  - If the winner equals last_idx and the win is contended, win_cnt+1 (saturating at STARVE_LIMIT). Otherwise win_cnt=1, or 0 if the win is uncontended.
  - When win_cnt reaches STARVE_LIMIT, set mask bit last_idx for the next arbitration only.
  - The mask clears once used, or when the masked master is the sole requester.
- Simultaneous request and B completion: requests sampled in the B-handshake cycle are arbitrated in that cycle.
- grant_index always equals the encoding of grant.

Decomposition:
- Shared package axi_ic_pkg: state encoding (IDLE/ADDR/DATA/RESP, 2-bit) and an index-width function.
- One sub-module, wr_prio_pick: combinational masked fixed-priority picker producing one-hot + index + any.
- FSM, counters and registers live in the top module.

Test Plan:
- Reset then s_awvalid=3'b110 -> next cycle grant=3'b010, grant_index=1, aw_en=1; AW handshake -> w_en=1.
- Owner 1 sends 4 W beats with wlast on beat 4 -> w_en drops the cycle after beat 4, b_en=1; B handshake with no requests -> grant=0, grant_valid=0.
- s_awvalid=3'b011 held constant, STARVE_LIMIT=4 -> grants 0,0,0,0,1,0,0,0,0,1; each burst starts 0 cycles after the previous B handshake.
- s_awvalid=3'b001 only, 6 bursts -> grant 0 every time (uncontended, never masked).
- rstn pulsed low during DATA -> outputs clear asynchronously; after release with s_awvalid=3'b100 -> grant=3'b100 one cycle later.
- W beats presented during ADDR before the AW handshake -> w_en stays 0; state stays ADDR until m_awready.
